// File: rtl/axis_fir_coef_ctrl.sv
// Runtime coefficient controller for the 9-tap AXI-Stream FIR.
// Collects a coefficient frame into a shadow bank. Once a complete frame
// has arrived, it closes the sample gate, lets the FIR multiply pipeline
// drain, and then loads the whole active bank in a single cycle.
module axis_fir_coef_ctrl #(
  parameter int data_width = 16,
  parameter int coefficient_width = 16,
  parameter int n_taps = 9,
  parameter int drain_cycles = 2,
  parameter logic [coefficient_width-1:0] coef_reset_b0 = 16'h7FFF
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic [coefficient_width-1:0]        s_cfg_tdata,
  input  logic                                s_cfg_tvalid,
  input  logic                                s_cfg_tlast,
  output logic                                s_cfg_tready,
  input  logic [data_width-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [data_width-1:0]               m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic [n_taps*coefficient_width-1:0] coef_out,
  output logic                                swap_pulse,
  output logic [7:0]                          swap_count,
  output logic                                cfg_error,
  input  logic                                cfg_error_clr
);

  localparam int IW = $clog2(n_taps + 1);
  localparam int DW = (drain_cycles < 2) ? 1 : $clog2(drain_cycles + 1);
  localparam logic [n_taps*coefficient_width-1:0] COEF_RESET =
    (n_taps*coefficient_width)'(coef_reset_b0);

  typedef enum logic [2:0] {IDLE, LOAD, DISCARD, DRAIN, SWAP} state_t;

  state_t                              r_state;
  state_t                              w_nextState;
  logic [coefficient_width-1:0]        r_shadow [n_taps];
  logic [IW-1:0]                       r_idx;
  logic [DW-1:0]                       r_drain;
  logic [n_taps*coefficient_width-1:0] r_coef;
  logic [7:0]                          r_swapCount;
  logic                                r_cfgError;

  logic w_gate;
  logic w_loading;
  logic w_cfgAccept;
  logic w_lastIdx;
  logic w_setError;

  // The gate is held closed while reset is asserted. It is also closed
  // for the whole drain/swap window, so the FIR never sees a sample
  // weighted by a half-updated bank.
  assign w_gate      = resetn && ((r_state == IDLE) || (r_state == LOAD) || (r_state == DISCARD));
  assign w_loading   = (r_state == IDLE) || (r_state == LOAD);
  assign w_cfgAccept = s_cfg_tvalid && w_gate;
  assign w_lastIdx   = (r_idx == IW'(n_taps - 1));
  // A malformed frame is detected in one of two ways: tlast arrives
  // before the last slot, or the last slot is filled without tlast.
  assign w_setError  = w_cfgAccept && w_loading && (w_lastIdx != s_cfg_tlast);

  assign s_cfg_tready  = w_gate;
  assign s_axis_tready = w_gate;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid && w_gate;
  assign coef_out      = r_coef;
  assign swap_pulse    = resetn && (r_state == SWAP);
  assign swap_count    = r_swapCount;
  assign cfg_error     = r_cfgError;

  // State register; any reset drops a partial or pending frame
  always_ff @(posedge aclk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state decode driven by config acceptance and the drain counter
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, LOAD: begin
        if (w_cfgAccept) begin
          if (w_lastIdx) w_nextState = s_cfg_tlast ? DRAIN : DISCARD;
          else           w_nextState = s_cfg_tlast ? IDLE : LOAD;
        end
      end
      DISCARD: if (w_cfgAccept && s_cfg_tlast) w_nextState = IDLE;
      DRAIN:   if (r_drain <= DW'(1)) w_nextState = SWAP;
      SWAP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Shadow bank fill, drain countdown and single-cycle bank swap
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      for (int k = 0; k < n_taps; k++) r_shadow[k] <= '0;
      r_idx       <= '0;
      r_drain     <= '0;
      r_coef      <= COEF_RESET;
      r_swapCount <= 8'd0;
    end else begin
      if (w_cfgAccept && w_loading) begin
        r_shadow[r_idx] <= s_cfg_tdata;
        r_idx           <= (w_nextState == LOAD) ? r_idx + IW'(1) : '0;
      end
      if (r_state == DRAIN)          r_drain <= r_drain - DW'(1);
      else if (w_nextState == DRAIN) r_drain <= DW'(drain_cycles);
      if (r_state == SWAP) begin
        for (int k = 0; k < n_taps; k++)
          r_coef[k*coefficient_width +: coefficient_width] <= r_shadow[k];
        r_swapCount <= r_swapCount + 8'd1;
        r_idx       <= '0;
      end
    end
  end

  // Sticky malformed-frame flag; a new error takes priority over a clear
  always_ff @(posedge aclk) begin
    if (!resetn)            r_cfgError <= 1'b0;
    else if (w_setError)    r_cfgError <= 1'b1;
    else if (cfg_error_clr) r_cfgError <= 1'b0;
  end

endmodule
